// File: rtl/me_train_pkg.sv
// -----------------------------------------------------------------------------
// me_train_pkg
// Shared definitions for the mutation-engine training sequencer.
//   - state_t      : sequencer states
//   - *_DEF        : default parameter values used by me_train_ctrl
//   - lane_lsb()   : bit offset of weight lane i inside a packed weight bus
// -----------------------------------------------------------------------------
package me_train_pkg;

  // Default geometry. NUM_W matches the number of mutation-engine lanes.
  localparam int NUM_W_DEF    = 4;
  localparam int W_W_DEF      = 8;
  localparam int EVAL_LEN_DEF = 256;
  localparam int ERR_W_DEF    = 16;
  localparam int MAX_ITER_DEF = 1024;
  // Weight value the engine produces out of its own reset; seeding uses it
  // so the committed set and the engine state agree after ME_RESET.
  localparam int INIT_W_DEF   = 100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_BASE    = 3'd2,
    S_MUTATE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_EVAL    = 3'd5,
    S_DECIDE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Lane i occupies bits [lane_lsb(i) +: w_w] of a packed weight bus.
  function automatic int lane_lsb(input int lane, input int w_w);
    return lane * w_w;
  endfunction

endpackage : me_train_pkg

// File: rtl/me_err_window.sv
// -----------------------------------------------------------------------------
// me_err_window
// Fixed-length evaluation window with a saturating error counter.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous, active-high reset
//   clear   in   synchronous clear of window position and error count
//   enable  in   window is running this cycle (count ERR_BIT, advance)
//   ERR_BIT in   per-cycle error flag
//   err     out  error count including this cycle's ERR_BIT when enabled;
//                equals the stored count when not enabled
//   last    out  high on the final enabled cycle of the window
// -----------------------------------------------------------------------------
module me_err_window #(
  parameter int EVAL_LEN = 256,
  parameter int ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             enable,
  input  logic             ERR_BIT,
  output logic [ERR_W-1:0] err,
  output logic             last
);

  localparam int WIN_W = (EVAL_LEN > 1) ? $clog2(EVAL_LEN) : 1;

  logic [WIN_W-1:0] win_cnt;
  logic [ERR_W-1:0] err_cnt;

  assign last = enable && (win_cnt == WIN_W'(EVAL_LEN - 1));

  // Running total seen through this cycle. The count sticks at all ones so a
  // long noisy window can never wrap around into a small, "good" score.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    err = err_cnt;
    if (enable && ERR_BIT && !(&err_cnt)) begin
      err = err_cnt + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (enable) begin
      err_cnt <= err;
      win_cnt <= last ? '0 : win_cnt + 1'b1;
    end
  end

endmodule : me_err_window

// File: rtl/me_train_ctrl.sv
// -----------------------------------------------------------------------------
// me_train_ctrl
// Training sequencer for the LFSR mutation engine. Seeds the engine, measures
// the baseline error of the committed weights, then repeatedly mutates,
// evaluates the candidate over a fixed window and commits it only when its
// error count is strictly lower than the best so far.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous, active-high reset
//   START    in   level; begins a run when sampled in IDLE or DONE
//   STOP     in   level; early-termination request, latched while busy
//   ERR_BIT  in   per-cycle SNN output/target mismatch flag
//   ME_OUT   in   candidate weights from the engine (lane i = [8i+7:8i])
//   ME_IN    out  committed weights fed back to the engine
//   ME_TRIG  out  one-cycle mutation strobe
//   ME_RESET out  one-cycle seed strobe
//   SNN_W    out  weights applied to the network
//   BUSY     out  high outside IDLE and DONE
//   DONE     out  high in DONE
//   BEST_ERR out  error count of the committed weights
//   ITER     out  completed mutation iterations
// -----------------------------------------------------------------------------
module me_train_ctrl
  import me_train_pkg::*;
#(
  parameter int NUM_W    = NUM_W_DEF,
  parameter int W_W      = W_W_DEF,
  parameter int EVAL_LEN = EVAL_LEN_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int INIT_W   = INIT_W_DEF,
  localparam int BUS_W   = NUM_W * W_W,
  localparam int IT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             ERR_BIT,
  input  logic [BUS_W-1:0] ME_OUT,
  output logic [BUS_W-1:0] ME_IN,
  output logic             ME_TRIG,
  output logic             ME_RESET,
  output logic [BUS_W-1:0] SNN_W,
  output logic             BUSY,
  output logic             DONE,
  output logic [ERR_W-1:0] BEST_ERR,
  output logic [IT_W-1:0]  ITER
);

  // Seed value replicated across every lane.
  logic [BUS_W-1:0] init_vec;
  for (genvar i = 0; i < NUM_W; i++) begin : g_init
    assign init_vec[lane_lsb(i, W_W) +: W_W] = W_W'(INIT_W);
  end

  state_t           state;
  logic [BUS_W-1:0] committed;
  logic [BUS_W-1:0] candidate;
  logic             stop_req;

  logic             win_clear;
  logic             win_enable;
  logic [ERR_W-1:0] err;
  logic             win_last;

  // The window is cleared in the single-cycle state that precedes each
  // counting phase, so BASE and EVAL always start from zero.
  assign win_clear  = (state == S_SEED) || (state == S_CAPTURE);
  assign win_enable = (state == S_BASE) || (state == S_EVAL);

  me_err_window #(
    .EVAL_LEN (EVAL_LEN),
    .ERR_W    (ERR_W)
  ) u_err_window (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (win_clear),
    .enable  (win_enable),
    .ERR_BIT (ERR_BIT),
    .err     (err),
    .last    (win_last)
  );

  assign ME_IN = committed;

  // Single-process FSM. Outputs are registered and updated on the edge that
  // enters the state in which they must be visible.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      committed <= init_vec;
      candidate <= init_vec;
      SNN_W     <= init_vec;
      BEST_ERR  <= '1;
      ITER      <= '0;
      stop_req  <= 1'b0;
      ME_TRIG   <= 1'b0;
      ME_RESET  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      // Strobes default low; only the entering transition raises them.
      ME_TRIG  <= 1'b0;
      ME_RESET <= 1'b0;

      // Stop is only honoured at DECIDE, so a request is held until then.
      if (BUSY && STOP) begin
        stop_req <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            // Seed values are loaded on entry so they are already visible
            // while the engine is being reset during SEED.
            state     <= S_SEED;
            ME_RESET  <= 1'b1;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            committed <= init_vec;
            candidate <= init_vec;
            SNN_W     <= init_vec;
            ITER      <= '0;
            stop_req  <= 1'b0;
          end
        end

        S_SEED: begin
          state <= S_BASE;
        end

        S_BASE: begin
          if (win_last) begin
            BEST_ERR <= err;
            ME_TRIG  <= 1'b1;
            state    <= S_MUTATE;
          end
        end

        S_MUTATE: begin
          state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // ME_OUT reflects the mutation triggered during MUTATE.
          candidate <= ME_OUT;
          SNN_W     <= ME_OUT;
          state     <= S_EVAL;
        end

        S_EVAL: begin
          if (win_last) begin
            SNN_W <= committed;
            state <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          // Strict comparison: ties keep the incumbent, and a saturated
          // candidate can never displace a saturated best.
          if (err < BEST_ERR) begin
            committed <= candidate;
            BEST_ERR  <= err;
            SNN_W     <= candidate;
          end
          ITER <= ITER + 1'b1;
          if ((int'(ITER) + 1 == MAX_ITER) || stop_req) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state   <= S_MUTATE;
            ME_TRIG <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : me_train_ctrl
